// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory boot loader.
//   loader_state_e  : loader FSM states
//   DefaultSyncByte : default frame start marker
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCheck,
    StDone,
    StError
  } loader_state_e;

  localparam logic [7:0] DefaultSyncByte = 8'hA5;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles lane-indexed bytes (lane 0 = LSB) into a 32-bit word and
// strobes word_valid for one cycle after the lane-3 byte is taken.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-low reset
//   byte_valid : byte_data is taken this cycle
//   lane       : byte lane 0..3 of byte_data
//   byte_data  : incoming byte
//   word       : assembled word, held until the next lane-3 byte
//   word_valid : one-cycle strobe, word is new this cycle
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  // Lanes 0..2 collect in a staging register so a lane-0 byte taken during the
  // word_valid cycle never disturbs the word being written.
  logic [23:0] stage_q;
  logic [31:0] word_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q <= 24'h0;
      word_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (byte_valid) begin
        unique case (lane)
          2'd0: stage_q[7:0]   <= byte_data;
          2'd1: stage_q[15:8]  <= byte_data;
          2'd2: stage_q[23:16] <= byte_data;
          2'd3: begin
            word_q  <= {byte_data, stage_q};
            valid_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer. Receives a framed byte stream
// (SYNC, N, 4*N payload bytes little-endian per word, XOR checksum), writes each
// word to imem and releases the core only after a frame with a good checksum.
// Ports:
//   clk, reset              : clock, synchronous active-low reset
//   InData/InValid/InReady  : byte stream, transfer = InValid & InReady
//   Start                   : re-arm pulse, honoured only in DONE/ERROR
//   IMemWE/IMemWA/IMemWD    : imem write port, one-cycle WE pulse per word
//   CpuHold                 : core reset, 1 = held (every state but DONE)
//   Done/Error              : frame loaded OK / bad length or checksum
//   WordCount               : words written in the current frame
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned MAX_WORDS  = 64,
  parameter logic [7:0]  SYNC_BYTE  = DefaultSyncByte
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            InData,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic                  Start,
  output logic                  IMemWE,
  output logic [ADDR_WIDTH-1:0] IMemWA,
  output logic [31:0]           IMemWD,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error,
  output logic [7:0]            WordCount
);

  loader_state_e state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [1:0]    lane_q, lane_d;
  logic [7:0]    rx_word_q, rx_word_d;    // words fully received
  logic [7:0]    word_idx_q, word_idx_d;  // words written; also the next write address
  logic [7:0]    xor_q, xor_d;

  logic        xfer;
  logic        in_active;
  logic        pack_valid;
  logic [31:0] pack_word;

  assign in_active = (state_q == StIdle) || (state_q == StLen) ||
                     (state_q == StData) || (state_q == StCheck);
  // Gated by reset so no byte is offered while the loader is held.
  assign InReady   = reset && in_active;
  assign xfer      = InValid && InReady;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    lane_d     = lane_q;
    rx_word_d  = rx_word_q;
    word_idx_d = word_idx_q;
    xor_d      = xor_q;

    if (pack_valid) begin
      word_idx_d = word_idx_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (xfer && (InData == SYNC_BYTE)) begin
          state_d   = StLen;
          lane_d    = 2'd0;
          rx_word_d = 8'd0;
          xor_d     = 8'd0;
        end
      end
      StLen: begin
        if (xfer) begin
          len_d = InData;
          if ((InData != 8'd0) && (32'(InData) <= MAX_WORDS)) begin
            state_d = StData;
          end else begin
            state_d = StError;
          end
        end
      end
      StData: begin
        if (xfer) begin
          xor_d  = xor_q ^ InData;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            rx_word_d = rx_word_q + 8'd1;
            if ((rx_word_q + 8'd1) == len_q) begin
              state_d = StCheck;
            end
          end
        end
      end
      StCheck: begin
        if (xfer) begin
          state_d = (InData == xor_q) ? StDone : StError;
        end
      end
      StDone, StError: begin
        if (Start) begin
          state_d    = StIdle;
          lane_d     = 2'd0;
          rx_word_d  = 8'd0;
          word_idx_d = 8'd0;
          xor_d      = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_q      <= 8'd0;
      lane_q     <= 2'd0;
      rx_word_q  <= 8'd0;
      word_idx_q <= 8'd0;
      xor_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      lane_q     <= lane_d;
      rx_word_q  <= rx_word_d;
      word_idx_q <= word_idx_d;
      xor_q      <= xor_d;
    end
  end

  byte_packer u_byte_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (xfer && (state_q == StData)),
    .lane       (lane_q),
    .byte_data  (InData),
    .word       (pack_word),
    .word_valid (pack_valid)
  );

  assign IMemWE    = pack_valid;
  assign IMemWA    = word_idx_q[ADDR_WIDTH-1:0];
  assign IMemWD    = pack_word;
  assign WordCount = word_idx_q;
  assign Done      = (state_q == StDone);
  assign Error     = (state_q == StError);
  assign CpuHold   = (state_q != StDone);

endmodule
